vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Time-slot arbiter that shares one single-port, 1-cycle-latency video RAM between the display fetch path and NREQ game-logic requesters (tank, shell, and map update engines). Display fetches are scheduled from the display timing generator's pixel counters and always win their slot; every remaining slot goes to requesters by round-robin with a req/gnt handshake. Output pixel words feed the colorizer at a fixed latency.

## Interface
- NREQ, 2: number of game-logic requesters (1..4)
- ADDR_W, 16: VRAM address width; display address is {row[9:2], col[9:2]}
- DATA_W, 8: VRAM word width (one word per 4x4-pixel block)
- HORIZ_PIXELS, 1024: visible columns
- VERT_PIXELS, 768: visible rows

- clock  in  1  pixel clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- pixel_row  in  11  current row from timing generator
- pixel_column  in  11  current column from timing generator
- disp_data  out  DATA_W  pixel word for current 4-column group
- disp_valid  out  1  disp_data holds a visible-area word
- req  in  NREQ  per-requester access request, level
- we  in  NREQ  1 = write, 0 = read; qualified by req
- addr  in  NREQ*ADDR_W  flattened requester addresses
- wdata  in  NREQ*DATA_W  flattened requester write data
- gnt  out  NREQ  one-hot, one-cycle grant pulse
- rdata  out  DATA_W  read data for the last granted read
- rvalid  out  NREQ  one-hot, one-cycle read-return pulse
- mem_en, mem_we  out  1  VRAM enable / write enable
- mem_addr  out  ADDR_W  VRAM address
- mem_wdata  out  DATA_W  VRAM write data
- mem_rdata  in  DATA_W  VRAM read data, valid 1 cycle after mem_en

## Operation
- Slot classification each cycle, from the counters registered this cycle:
  - DISP: pixel_row < VERT_PIXELS, pixel_column < HORIZ_PIXELS, pixel_column[1:0] == 0.
  - FREE: every other cycle, including all horizontal and vertical blanking.
- DISP slot: mem_en=1, mem_we=0, mem_addr={pixel_row[9:2], pixel_column[9:2]}, zero-extended to ADDR_W. No grant is issued.
- FREE slot: a round-robin arbiter picks the first asserted req at or after pointer rr_ptr, then wrapping. It drives gnt[i]=1 and mem_* from requester i, then sets rr_ptr=(i+1) mod NREQ. With no req, mem_en=0 and rr_ptr holds.
- Requester rules:
  - req, we, addr, and wdata stay stable from req assertion until the gnt cycle.
  - req may be dropped on the cycle after gnt, or held to request again.
  - Withdrawing req before gnt is illegal.
- Read return: rvalid[i] pulses with rdata=mem_rdata one cycle after gnt[i] with we[i]=0. A write produces no rvalid.
- Display return: a 2-stage tag pipeline marks DISP reads. disp_data/disp_valid load 2 cycles after the DISP slot and hold for 4 cycles. disp_valid=0 outside the visible area.
- Display always has priority: a FREE-eligible req arriving in a DISP slot waits; a requester waits at most 1 DISP slot plus NREQ-1 FREE slots.
- Reset (rst_n=0 at posedge):
  - gnt, rvalid, mem_en, mem_we, and disp_valid are 0.
  - disp_data, rdata, mem_addr, and mem_wdata are 0.
  - rr_ptr and the tag pipeline are 0.
  - In-flight returns are discarded: no rvalid after reset.

## Timing
- Grant latency: same-cycle combinational decode, registered onto gnt and mem_* at the next posedge. Requester sees gnt 1 cycle after a FREE slot with req.
- Read latency: gnt to rvalid = 1 cycle; req to rvalid ≥ 2 cycles.
- Display latency: counter value to disp_data = 2 cycles; the colorizer delays video_on by 2 to match.
- Wrap-around: at pixel_column 1023→1024 no further DISP slots occur; column/row wrap from the timing generator needs no special handling.
- Bandwidth: exactly 1 DISP per 4 visible cycles.

## Configuration
- VRAM_ARB_VBLANK_WRITE_EN defined:
  - Write grants are issued only when pixel_row ≥ VERT_PIXELS (tear-free updates).
  - Write requests elsewhere are skipped by the arbiter and rr_ptr does not pass them.
  - Reads are unaffected.
- Undefined: writes are granted in any FREE slot.

## Structure
- Package vram_arb_pkg holds:
  - default ADDR_W, DATA_W, and NREQ constants;
  - slot-type enum (SLOT_DISP, SLOT_FREE);
  - the function forming the display address from row/column.
- Sub-module rr_arbiter (parameter NREQ): inputs req vector, eligibility mask, and advance strobe; outputs one-hot grant and pointer.

## Test plan
- Reset mid-read: rst_n low the cycle after gnt[0] → no rvalid; all outputs 0; rr_ptr=0.
- Visible line, no req: row 10, columns 0..1023 → mem_en every 4th cycle; mem_addr=0x0200+col/4; disp_data matches VRAM 2 cycles later; disp_valid=1.
- Two requesters, continuous reads in hblank (column 1100): gnt alternates 01,10,01; rvalid follows 1 cycle later with the correct rdata.
- Collision: req[1] asserted at column 4 (DISP slot) → gnt[1] at column 5 slot; display read at 4 unaffected.
- Write then read address 0x1234, data 0xA5, in FREE slots → rvalid with rdata=0xA5.
- With VRAM_ARB_VBLANK_WRITE_EN: write req at row 100 → no gnt until row 768; concurrent read req on other port granted meanwhile.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared defaults, slot type and display address helper for vram_arbiter
package vram_arb_pkg;
  localparam int DEF_NREQ = 2;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;
  typedef enum logic {SLOT_DISP, SLOT_FREE} slot_t;
  function automatic logic [15:0] disp_addr(input logic [7:0] row_blk, input logic [7:0] col_blk);
    return {row_blk, col_blk};
  endfunction
endpackage

// File: rtl/vram_arbiter_rr.sv
// rr_arbiter: round-robin pick among eligible requests; the pointer never moves past a pending ineligible request
module rr_arbiter
  import vram_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            i_clock,
  input  logic            i_rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_elig,
  input  logic            i_adv,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_ptr
);
  logic [PW-1:0] r_ptr, w_any_idx, w_el_idx;
  logic w_any, w_el;
  always_comb begin
    o_gnt = '0;
    w_any = 1'b0;
    w_el = 1'b0;
    w_any_idx = r_ptr;
    w_el_idx = r_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && i_req[(int'(r_ptr) + k) % NREQ]) begin
        w_any = 1'b1;
        w_any_idx = PW'((int'(r_ptr) + k) % NREQ);
      end
      if (!w_el && i_req[(int'(r_ptr) + k) % NREQ] && i_elig[(int'(r_ptr) + k) % NREQ]) begin
        w_el = 1'b1;
        w_el_idx = PW'((int'(r_ptr) + k) % NREQ);
      end
    end
    if (w_el) o_gnt[w_el_idx] = 1'b1;
  end
  always_ff @(posedge i_clock) begin
    if (!i_rst_n) r_ptr <= '0;
    else if (i_adv && w_el) r_ptr <= (w_any_idx == w_el_idx) ? PW'((int'(w_el_idx) + 1) % NREQ) : w_any_idx;
  end
  assign o_ptr = r_ptr;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a 1-cycle VRAM between display fetch (every 4th visible pixel) and round-robin requesters.
// Define VRAM_ARB_VBLANK_WRITE_EN to grant requester writes only during vertical blanking.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int HORIZ_PIXELS = 1024,
  parameter int VERT_PIXELS = 768
) (
  input  logic                   i_clock,
  input  logic                   i_rst_n,
  input  logic [10:0]            i_pixel_row,
  input  logic [10:0]            i_pixel_column,
  output logic [DATA_W-1:0]      o_disp_data,
  output logic                   o_disp_valid,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ-1:0]        i_we,
  input  logic [NREQ*ADDR_W-1:0] i_addr,
  input  logic [NREQ*DATA_W-1:0] i_wdata,
  output logic [NREQ-1:0]        o_gnt,
  output logic [DATA_W-1:0]      o_rdata,
  output logic [NREQ-1:0]        o_rvalid,
  output logic                   o_mem_en,
  output logic                   o_mem_we,
  output logic [ADDR_W-1:0]      o_mem_addr,
  output logic [DATA_W-1:0]      o_mem_wdata,
  input  logic [DATA_W-1:0]      i_mem_rdata
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [10:0] HP = 11'(HORIZ_PIXELS);
  localparam logic [10:0] VP = 11'(VERT_PIXELS);
  slot_t w_slot;
  logic w_disp, w_sel_we;
  logic [NREQ-1:0] w_req, w_elig, w_gnt, r_gnt, r_rvalid;
  logic [ADDR_W-1:0] w_sel_addr, r_mem_addr;
  logic [DATA_W-1:0] w_sel_wdata, r_mem_wdata, r_rdata, r_disp_data;
  logic [PW-1:0] w_unused_ptr;
  logic [1:0] r_tag, r_hold;
  logic r_mem_en, r_mem_we;
  assign w_slot = (i_pixel_row < VP && i_pixel_column < HP && i_pixel_column[1:0] == 2'd0) ? SLOT_DISP : SLOT_FREE;
  assign w_disp = w_slot == SLOT_DISP;
  // a requester still holds req during its own gnt cycle; that is not a fresh request
  assign w_req = i_req & ~r_gnt;
`ifdef VRAM_ARB_VBLANK_WRITE_EN
  assign w_elig = ~i_we | {NREQ{i_pixel_row >= VP}};
`else
  assign w_elig = '1;
`endif
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_clock(i_clock),
    .i_rst_n(i_rst_n),
    .i_req(w_req),
    .i_elig(w_elig),
    .i_adv(!w_disp),
    .o_gnt(w_gnt),
    .o_ptr(w_unused_ptr)
  );
  always_comb begin
    w_sel_we = 1'b0;
    w_sel_addr = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_gnt[i]) begin
        w_sel_we = i_we[i];
        w_sel_addr = i_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = i_wdata[i*DATA_W +: DATA_W];
      end
  end
  always_ff @(posedge i_clock) begin
    if (!i_rst_n) begin
      r_gnt <= '0;
      r_rvalid <= '0;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_addr <= '0;
      r_mem_wdata <= '0;
      r_tag <= '0;
      r_hold <= '0;
      r_rdata <= '0;
      r_disp_data <= '0;
    end else begin
      r_gnt <= w_disp ? '0 : w_gnt;
      r_mem_en <= w_disp || |w_gnt;
      r_mem_we <= !w_disp && w_sel_we;
      r_mem_addr <= w_disp ? ADDR_W'(disp_addr(i_pixel_row[9:2], i_pixel_column[9:2])) : w_sel_addr;
      r_mem_wdata <= w_disp ? '0 : w_sel_wdata;
      r_rvalid <= r_gnt & {NREQ{!r_mem_we}};
      r_rdata <= o_rdata;
      r_tag <= {r_tag[0], w_disp};
      r_hold <= r_tag[1] ? 2'd3 : (r_hold != 2'd0 ? r_hold - 2'd1 : 2'd0);
      r_disp_data <= o_disp_data;
    end
  end
  // returns pass straight from the RAM in their arrival cycle, then hold in r_rdata / r_disp_data
  assign o_rdata = |r_rvalid ? i_mem_rdata : r_rdata;
  assign o_disp_data = r_tag[1] ? i_mem_rdata : r_disp_data;
  assign o_disp_valid = r_tag[1] || r_hold != 2'd0;
  assign o_gnt = r_gnt;
  assign o_rvalid = r_rvalid;
  assign o_mem_en = r_mem_en;
  assign o_mem_we = r_mem_we;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed vector table plus corner-case sequences for vram_arbiter
module tb_vram_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [10:0] row, col;
  logic [1:0] req, we, gnt, rvalid;
  logic [15:0] a0, a1, mem_addr;
  logic [7:0] wd0, wd1, disp_data, rdata, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic disp_valid, mem_en, mem_we;
  logic [7:0] vram [0:65535];
  int n_tests = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [10:0] row, col;
    logic [1:0] req, we;
    logic [15:0] a0, a1;
    logic [7:0] wd0, wd1;
    logic en, mwe;
    logic [1:0] g;
    logic [15:0] addr;
    logic [7:0] wdata;
  } vec_t;
  vec_t vecs [0:14];

  always #5 clk = ~clk;

  vram_arbiter dut (
    .i_clock(clk), .i_rst_n(rst_n), .i_pixel_row(row), .i_pixel_column(col),
    .o_disp_data(disp_data), .o_disp_valid(disp_valid),
    .i_req(req), .i_we(we), .i_addr({a1, a0}), .i_wdata({wd1, wd0}),
    .o_gnt(gnt), .o_rdata(rdata), .o_rvalid(rvalid),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) vram[mem_addr] <= mem_wdata;
      else mem_rdata <= vram[mem_addr];
    end

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [10:0] r, input logic [10:0] c, input logic [1:0] q, input logic [1:0] w,
                       input logic [15:0] x0, input logic [15:0] x1, input logic [7:0] d0, input logic [7:0] d1);
    row = r; col = c; req = q; we = w; a0 = x0; a1 = x1; wd0 = d0; wd1 = d1;
  endtask

  task automatic idle(input logic [10:0] r, input logic [10:0] c);
    drive(r, c, 2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle(11'd900, 11'd0);
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) vram[i] = pat(16'(i));
    vecs = '{
      '{11'd10,  11'd0,    2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 16'h0200, 8'h00},
      '{11'd10,  11'd1,    2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 16'h0000, 8'h00},
      '{11'd10,  11'd4,    2'b11, 2'b00, 16'h0100, 16'h0101, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 16'h0201, 8'h00},
      '{11'd10,  11'd5,    2'b11, 2'b00, 16'h0100, 16'h0101, 8'h00, 8'h00, 1'b1, 1'b0, 2'b01, 16'h0100, 8'h00},
      '{11'd10,  11'd6,    2'b11, 2'b00, 16'h0100, 16'h0101, 8'h00, 8'h00, 1'b1, 1'b0, 2'b10, 16'h0101, 8'h00},
      '{11'd10,  11'd7,    2'b01, 2'b00, 16'h0100, 16'h0101, 8'h00, 8'h00, 1'b1, 1'b0, 2'b01, 16'h0100, 8'h00},
      '{11'd10,  11'd8,    2'b10, 2'b00, 16'h0100, 16'h0101, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 16'h0202, 8'h00},
      '{11'd10,  11'd9,    2'b10, 2'b00, 16'h0100, 16'h0101, 8'h00, 8'h00, 1'b1, 1'b0, 2'b10, 16'h0101, 8'h00},
      '{11'd800, 11'd0,    2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 16'h0000, 8'h00},
      '{11'd10,  11'd1024, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 16'h0000, 8'h00},
      '{11'd767, 11'd1020, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 16'hBFFF, 8'h00},
      '{11'd800, 11'd3,    2'b10, 2'b10, 16'h0000, 16'h0300, 8'h00, 8'h11, 1'b1, 1'b1, 2'b10, 16'h0300, 8'h11},
      '{11'd768, 11'd0,    2'b01, 2'b01, 16'h0301, 16'h0000, 8'h22, 8'h00, 1'b1, 1'b1, 2'b01, 16'h0301, 8'h22},
      '{11'd768, 11'd4,    2'b11, 2'b00, 16'h0310, 16'h0311, 8'h00, 8'h00, 1'b1, 1'b0, 2'b10, 16'h0311, 8'h00},
      '{11'd767, 11'd1024, 2'b01, 2'b00, 16'h0310, 16'h0311, 8'h00, 8'h00, 1'b1, 1'b0, 2'b01, 16'h0310, 8'h00}
    };
    // reset state: a DISP slot and live requests must not leak through
    drive(11'd10, 11'd0, 2'b11, 2'b00, 16'h0010, 16'h0011, 8'h0, 8'h0);
    tick;
    tick;
    check("rst gnt", gnt, 2'b00);
    check("rst rvalid", rvalid, 2'b00);
    check("rst mem_en", mem_en, 1'b0);
    check("rst mem_we", mem_we, 1'b0);
    check("rst mem_addr", mem_addr, 16'h0);
    check("rst mem_wdata", mem_wdata, 8'h0);
    check("rst disp_valid", disp_valid, 1'b0);
    check("rst disp_data", disp_data, 8'h0);
    check("rst rdata", rdata, 8'h0);
    do_reset;
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].row, vecs[i].col, vecs[i].req, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].wd0, vecs[i].wd1);
      tick;
      check($sformatf("v%0d mem_en", i), mem_en, vecs[i].en);
      check($sformatf("v%0d gnt", i), gnt, vecs[i].g);
      check($sformatf("v%0d mem_we", i), mem_we, vecs[i].mwe);
      if (vecs[i].en) check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].addr);
      if (vecs[i].mwe) check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].wdata);
    end
    // reset the cycle after a read grant: the return is dropped and the pointer restarts at 0
    do_reset;
    drive(11'd900, 11'd0, 2'b01, 2'b00, 16'h0010, 16'h0011, 8'h0, 8'h0);
    tick;
    check("A gnt", gnt, 2'b01);
    rst_n = 1'b0;
    idle(11'd900, 11'd1);
    tick;
    check("A rst rvalid", rvalid, 2'b00);
    check("A rst gnt", gnt, 2'b00);
    check("A rst mem_en", mem_en, 1'b0);
    rst_n = 1'b1;
    tick;
    check("A post rvalid", rvalid, 2'b00);
    check("A post rdata", rdata, 8'h00);
    drive(11'd900, 11'd2, 2'b11, 2'b00, 16'h0010, 16'h0011, 8'h0, 8'h0);
    tick;
    check("A ptr gnt", gnt, 2'b01);
    idle(11'd900, 11'd3);
    tick;
    check("A rvalid", rvalid, 2'b01);
    check("A rdata", rdata, pat(16'h0010));
    // full visible line, no requests
    for (int i = 0; i < 6; i++) begin
      idle(11'd900, 11'd0);
      tick;
    end
    for (int k = 0; k < 1028; k++) begin
      idle(11'd10, 11'(k));
      tick;
      check($sformatf("B c%0d mem_en", k), mem_en, k < 1024 && k % 4 == 0);
      if (mem_en) check($sformatf("B c%0d addr", k), mem_addr, 16'h0200 | 16'(k >> 2));
      check($sformatf("B c%0d disp_valid", k), disp_valid, k >= 1 && k <= 1024);
      if (k >= 1 && k <= 1024) check($sformatf("B c%0d disp_data", k), disp_data, pat(16'h0200 | 16'((k - 1) >> 2)));
    end
    // continuous reads in horizontal blanking
    do_reset;
    for (int i = 0; i < 3; i++) begin
      drive(11'd10, 11'd1100, 2'b11, 2'b00, 16'h0040, 16'h0041, 8'h0, 8'h0);
      tick;
      check($sformatf("C%0d gnt", i), gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) begin
        check($sformatf("C%0d rvalid", i), rvalid, (i % 2 == 1) ? 2'b01 : 2'b10);
        check($sformatf("C%0d rdata", i), rdata, pat((i % 2 == 1) ? 16'h0040 : 16'h0041));
      end
    end
    idle(11'd10, 11'd1100);
    tick;
    check("C3 gnt", gnt, 2'b00);
    check("C3 rvalid", rvalid, 2'b01);
    check("C3 rdata", rdata, pat(16'h0040));
    tick;
    check("C4 rvalid", rvalid, 2'b00);
    check("C4 rdata hold", rdata, pat(16'h0040));
    // request arriving in a DISP slot waits one slot
    do_reset;
    idle(11'd10, 11'd3);
    tick;
    drive(11'd10, 11'd4, 2'b10, 2'b00, 16'h0, 16'h0050, 8'h0, 8'h0);
    tick;
    check("D disp en", mem_en, 1'b1);
    check("D disp addr", mem_addr, 16'h0201);
    check("D disp gnt", gnt, 2'b00);
    drive(11'd10, 11'd5, 2'b10, 2'b00, 16'h0, 16'h0050, 8'h0, 8'h0);
    tick;
    check("D gnt", gnt, 2'b10);
    check("D addr", mem_addr, 16'h0050);
    check("D disp_valid", disp_valid, 1'b1);
    check("D disp_data", disp_data, pat(16'h0201));
    idle(11'd10, 11'd6);
    tick;
    check("D rvalid", rvalid, 2'b10);
    check("D rdata", rdata, pat(16'h0050));
    check("D disp_data hold", disp_data, pat(16'h0201));
    // write 0xA5 to 0x1234 then read it back
    do_reset;
    drive(11'd900, 11'd0, 2'b01, 2'b01, 16'h1234, 16'h0, 8'hA5, 8'h0);
    tick;
    check("E wr gnt", gnt, 2'b01);
    check("E wr we", mem_we, 1'b1);
    check("E wr addr", mem_addr, 16'h1234);
    check("E wr data", mem_wdata, 8'hA5);
    idle(11'd900, 11'd1);
    tick;
    check("E wr rvalid", rvalid, 2'b00);
    drive(11'd900, 11'd2, 2'b01, 2'b00, 16'h1234, 16'h0, 8'h0, 8'h0);
    tick;
    check("E rd gnt", gnt, 2'b01);
    check("E rd we", mem_we, 1'b0);
    idle(11'd900, 11'd3);
    tick;
    check("E rvalid", rvalid, 2'b01);
    check("E rdata", rdata, 8'hA5);
`ifdef VRAM_ARB_VBLANK_WRITE_EN
    do_reset;
    for (int i = 0; i < 4; i++) begin
      drive(11'd100, 11'd1100, 2'b11, 2'b01, 16'h2000, 16'h0041, 8'h5A, 8'h0);
      tick;
      check($sformatf("F%0d gnt", i), gnt, (i % 2 == 0) ? 2'b10 : 2'b00);
    end
    drive(11'd768, 11'd1100, 2'b11, 2'b01, 16'h2000, 16'h0041, 8'h5A, 8'h0);
    tick;
    check("F vblank gnt", gnt, 2'b01);
    check("F vblank we", mem_we, 1'b1);
`else
    do_reset;
    drive(11'd100, 11'd1100, 2'b01, 2'b01, 16'h2000, 16'h0, 8'h5A, 8'h0);
    tick;
    check("F gnt", gnt, 2'b01);
    check("F we", mem_we, 1'b1);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
